// File: rtl/chu_gpi_event.sv
// chu_gpi_event: general-purpose input slot for the MMIO slot bus.
// Samples a W-bit asynchronous input through a 2-FF synchronizer, optionally
// debounces it, latches rising/falling edges as sticky write-1-to-clear flags
// and raises a registered, masked level interrupt.
// Optional debounce filter: define GPI_DEBOUNCE_EN (sample period DB_CNT clks).
// Register map: 0 LEVEL (RO), 1 RISE (W1C), 2 FALL (W1C), 3 MASK (R/W),
// 4..31 read as zero.
module chu_gpi_event #(
    parameter int W      = 8,
    parameter int DB_CNT = 50000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    input  logic [W-1:0] din,
    output logic         irq
);

    logic [W-1:0] sync1_r;
    logic [W-1:0] sync2_r;
    logic [W-1:0] stable_r;
    logic [W-1:0] stable_d_r;
    logic [W-1:0] rise_r;
    logic [W-1:0] fall_r;
    logic [W-1:0] mask_r;
    logic         irq_r;

    logic [W-1:0] rise_s;
    logic [W-1:0] fall_s;
    logic [W-1:0] clr_rise_s;
    logic [W-1:0] clr_fall_s;
    logic         wr_s;
    logic         unused_s;

    // Two-flop synchronizer bringing din into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= {W{1'b0}};
            sync2_r <= {W{1'b0}};
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

`ifdef GPI_DEBOUNCE_EN
    localparam int CNT_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

    logic [CNT_W-1:0] cnt_r;
    logic [W-1:0]     samp_r;
    logic [W-1:0]     agree_s;
    logic             tick_s;

    assign tick_s   = (cnt_r == CNT_W'(DB_CNT - 1));
    assign agree_s  = ~(sync2_r ^ samp_r);
    assign unused_s = ^{read, wr_data};

    // Free-running prescaler that produces one tick every DB_CNT cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // A bit is accepted only when it reads the same on two consecutive ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_r   <= {W{1'b0}};
            stable_r <= {W{1'b0}};
        end else if (tick_s) begin
            samp_r   <= sync2_r;
            stable_r <= (stable_r & ~agree_s) | (sync2_r & agree_s);
        end
    end
`else
    assign unused_s = ^{read, wr_data, (DB_CNT > 1)};

    // Without the filter the accepted level is the synchronizer output, one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_r <= {W{1'b0}};
        end else begin
            stable_r <= sync2_r;
        end
    end
`endif

    assign rise_s     = stable_r & ~stable_d_r;
    assign fall_s     = ~stable_r & stable_d_r;
    assign wr_s       = cs & write;
    assign clr_rise_s = (wr_s && (addr == 5'd1)) ? wr_data[W-1:0] : {W{1'b0}};
    assign clr_fall_s = (wr_s && (addr == 5'd2)) ? wr_data[W-1:0] : {W{1'b0}};

    // Previous accepted level, used to turn level changes into one-cycle edge pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_d_r <= {W{1'b0}};
        end else begin
            stable_d_r <= stable_r;
        end
    end

    // Sticky edge flags; a new edge in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_r <= {W{1'b0}};
            fall_r <= {W{1'b0}};
        end else begin
            rise_r <= (rise_r & ~clr_rise_s) | rise_s;
            fall_r <= (fall_r & ~clr_fall_s) | fall_s;
        end
    end

    // Software-written interrupt enable per input bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_r <= {W{1'b0}};
        end else if (wr_s && (addr == 5'd3)) begin
            mask_r <= wr_data[W-1:0];
        end
    end

    // Registered level interrupt from any enabled pending event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |((rise_r | fall_r) & mask_r);
        end
    end

    assign irq = irq_r;

    // Same-cycle read mux; deselected slot and unmapped addresses return zero.
    always_comb begin
        rd_data = 32'h0000_0000;
        if (cs) begin
            case (addr)
                5'd0:    rd_data = 32'(stable_r);
                5'd1:    rd_data = 32'(rise_r);
                5'd2:    rd_data = 32'(fall_r);
                5'd3:    rd_data = 32'(mask_r);
                default: rd_data = 32'h0000_0000;
            endcase
        end else begin
            rd_data = 32'h0000_0000;
        end
    end

endmodule
